// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the functional units and the CDB arbiter.
// master = requester/consumer side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [2:0]                cdb_src;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter with registered tag/data broadcast.
// Optional per-unit saturating grant counters under CDB_GRANT_COUNT_EN.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  cdb_arbiter_if.slave       bus,
  input  logic [2:0]         perf_sel,
  output logic [15:0]        perf_count
);

  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [2:0]        cdb_src_q, cdb_src_d;

  logic              found;
  logic [2:0]        grant_idx;
  logic [3:0]        cand;

  // Walk candidates rr_ptr, rr_ptr+1, ... folding back below NUM_REQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!flush) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        cand = {1'b0, rr_ptr_q} + 4'(off);
        if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (!found && cand == 4'(i) && bus.req_valid[i]) begin
            found     = 1'b1;
            grant_idx = 3'(i);
          end
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    rr_ptr_d      = rr_ptr_q;
    cdb_valid_d   = found;
    cdb_tag_d     = cdb_tag_q;
    cdb_data_d    = cdb_data_q;
    cdb_src_d     = cdb_src_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (found && grant_idx == 3'(i)) begin
        bus.req_ready[i] = 1'b1;
        cdb_tag_d        = bus.req_tag[i*TAG_W +: TAG_W];
        cdb_data_d       = bus.req_data[i*DATA_W +: DATA_W];
        cdb_src_d        = 3'(i);
        rr_ptr_d         = (i == NUM_REQ - 1) ? 3'd0 : 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;

`ifdef CDB_GRANT_COUNT_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  always_comb begin
    perf_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (found && grant_idx == 3'(i) && cnt_q[i] != '1)
        cnt_d[i] = cnt_q[i] + 16'd1;
      if (perf_sel == 3'(i))
        perf_count = cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  logic unused_perf_sel;
  assign unused_perf_sel = ^perf_sel;
  assign perf_count      = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter: table of per-cycle stimulus and
// expected grant/broadcast, plus hand sequences for reset, counters, starvation.
module tb_cdb_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned DATA_W  = 32;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [2:0]  perf_sel;
  logic [15:0] perf_count;

  int n_cmp;
  int n_bad;

  cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus.slave),
    .perf_sel   (perf_sel),
    .perf_count (perf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [3:0]  rv;
    logic        sp;   // unit 2 carries tag 17 / DEADBEEF instead of its default
    logic [3:0]  er;
    logic        ev;
    logic [2:0]  es;
    logic [5:0]  et;
    logic [31:0] ed;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(input logic fl, input logic [3:0] rv, input logic sp,
                               input logic [3:0] er, input logic ev, input logic [2:0] es,
                               input logic [5:0] et, input logic [31:0] ed);
    vec_t v;
    v.fl = fl; v.rv = rv; v.sp = sp; v.er = er;
    v.ev = ev; v.es = es; v.et = et; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [3:0] rv, input logic sp);
    flush         = fl;
    bus.req_valid = rv;
    for (int i = 0; i < 4; i++) begin
      bus.req_tag[i*6 +: 6]    = 6'(10 + i);
      bus.req_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    end
    if (sp) begin
      bus.req_tag[12 +: 6]  = 6'd17;
      bus.req_data[64 +: 32] = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    perf_sel = 3'd0;
    drive(1'b0, 4'b0000, 1'b0);

    // fl, rv, sp, exp_ready, exp_valid, exp_src, exp_tag, exp_data
    vq.push_back(mkv(0, 4'b0000, 0, 4'b0000, 0, 0, 0,  32'h0));
    vq.push_back(mkv(0, 4'b0000, 0, 4'b0000, 0, 0, 0,  32'h0));
    vq.push_back(mkv(0, 4'b1111, 0, 4'b0001, 0, 0, 0,  32'h0));
    vq.push_back(mkv(0, 4'b1111, 0, 4'b0010, 1, 0, 10, 32'hC0DE0000));
    vq.push_back(mkv(0, 4'b1111, 0, 4'b0100, 1, 1, 11, 32'hC0DE0001));
    vq.push_back(mkv(0, 4'b1111, 0, 4'b1000, 1, 2, 12, 32'hC0DE0002));
    vq.push_back(mkv(0, 4'b1111, 0, 4'b0001, 1, 3, 13, 32'hC0DE0003));
    vq.push_back(mkv(0, 4'b1111, 0, 4'b0010, 1, 0, 10, 32'hC0DE0000));
    vq.push_back(mkv(0, 4'b1111, 0, 4'b0100, 1, 1, 11, 32'hC0DE0001));
    vq.push_back(mkv(0, 4'b1111, 0, 4'b1000, 1, 2, 12, 32'hC0DE0002));
    vq.push_back(mkv(0, 4'b0000, 0, 4'b0000, 1, 3, 13, 32'hC0DE0003));
    vq.push_back(mkv(0, 4'b0000, 0, 4'b0000, 0, 3, 13, 32'hC0DE0003));
    vq.push_back(mkv(0, 4'b0100, 1, 4'b0100, 0, 3, 13, 32'hC0DE0003));
    vq.push_back(mkv(0, 4'b0000, 0, 4'b0000, 1, 2, 17, 32'hDEADBEEF));
    vq.push_back(mkv(0, 4'b0000, 0, 4'b0000, 0, 2, 17, 32'hDEADBEEF));
    vq.push_back(mkv(1, 4'b1001, 0, 4'b0000, 0, 2, 17, 32'hDEADBEEF));
    vq.push_back(mkv(0, 4'b1001, 0, 4'b1000, 0, 2, 17, 32'hDEADBEEF));
    vq.push_back(mkv(0, 4'b0001, 0, 4'b0001, 1, 3, 13, 32'hC0DE0003));
    vq.push_back(mkv(0, 4'b0010, 0, 4'b0010, 1, 0, 10, 32'hC0DE0000));
    vq.push_back(mkv(0, 4'b0011, 0, 4'b0001, 1, 1, 11, 32'hC0DE0001));
    vq.push_back(mkv(0, 4'b0010, 0, 4'b0010, 1, 0, 10, 32'hC0DE0000));
    vq.push_back(mkv(0, 4'b0000, 0, 4'b0000, 1, 1, 11, 32'hC0DE0001));
    vq.push_back(mkv(0, 4'b0000, 0, 4'b0000, 0, 1, 11, 32'hC0DE0001));
    vq.push_back(mkv(0, 4'b1000, 0, 4'b1000, 0, 1, 11, 32'hC0DE0001));
    vq.push_back(mkv(1, 4'b0001, 0, 4'b0000, 1, 3, 13, 32'hC0DE0003));
    vq.push_back(mkv(0, 4'b0001, 0, 4'b0001, 0, 3, 13, 32'hC0DE0003));
    vq.push_back(mkv(0, 4'b0000, 0, 4'b0000, 1, 0, 10, 32'hC0DE0000));
    vq.push_back(mkv(0, 4'b0000, 0, 4'b0000, 0, 0, 10, 32'hC0DE0000));

    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].fl, vq[k].rv, vq[k].sp);
      #1;
      chk($sformatf("v%0d req_ready", k), 32'(bus.req_ready), 32'(vq[k].er));
      chk($sformatf("v%0d cdb_valid", k), 32'(bus.cdb_valid), 32'(vq[k].ev));
      chk($sformatf("v%0d cdb_src", k),   32'(bus.cdb_src),   32'(vq[k].es));
      chk($sformatf("v%0d cdb_tag", k),   32'(bus.cdb_tag),   32'(vq[k].et));
      chk($sformatf("v%0d cdb_data", k),  bus.cdb_data,       vq[k].ed);
    end

    // Clean reset, then five handshakes by unit 1 with perf_sel=1.
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    perf_sel = 3'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, 4'b0010, 1'b0);
      #1;
      chk($sformatf("perf hs%0d req_ready", k), 32'(bus.req_ready), 32'h2);
    end
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b0);
    #1;
`ifdef CDB_GRANT_COUNT_EN
    chk("perf_count unit1", 32'(perf_count), 32'd5);
`else
    chk("perf_count tied0 sel1", 32'(perf_count), 32'd0);
`endif
    perf_sel = 3'd0;
    #1 chk("perf_count unit0", 32'(perf_count), 32'd0);
    perf_sel = 3'd5;
    #1 chk("perf_count sel5", 32'(perf_count), 32'd0);
    perf_sel = 3'd1;

    // rr_ptr is now 2: all requesting grants unit 2, then reset mid-broadcast.
    @(negedge clk);
    drive(1'b0, 4'b1111, 1'b0);
    #1 chk("mid req_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk);
    #2;
    chk("mid cdb_valid", 32'(bus.cdb_valid), 32'd1);
    chk("mid cdb_tag", 32'(bus.cdb_tag), 32'd12);
    reset = 1'b1;
    #1;
    chk("async cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("async cdb_src", 32'(bus.cdb_src), 32'd0);
    chk("async cdb_tag", 32'(bus.cdb_tag), 32'd0);
    chk("async perf_count", 32'(perf_count), 32'd0);
    chk("async rr_ptr ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Starvation bound: unit 3 under full contention granted within NUM_REQ cycles.
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < NUM_REQ && !seen; c++) begin
        @(negedge clk);
        drive(1'b0, 4'b1111, 1'b0);
        #1;
        if (bus.req_ready[3]) seen = 1'b1;
        else @(posedge clk);
      end
      chk("starvation unit3 granted", 32'(seen), 32'd1);
    end

    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b0);
    #1 chk("idle req_ready", 32'(bus.req_ready), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) among NUM_REQ functional units (ALU, MUL, LSU, branch) that have completed results.
- Grants one requester per cycle using round-robin priority and registers the winning tag and data onto the CDB.
- The CDB outputs feed the reservation stations' wakeup ports (cdb_valid/cdb_tag) and the PRF write port.
- A synchronous flush kills any pending broadcast on branch mispredict recovery.

Parameters:
- NUM_REQ, 4, number of requesting functional units (2..8).
- TAG_W, 6, physical register tag width.
- DATA_W, 32, result data width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill: suppresses grant and broadcast this cycle.
- req_valid  input  NUM_REQ  per-unit result-pending request; bit i = unit i.
- req_tag  input  NUM_REQ*TAG_W  flattened dest tags; unit i at [i*TAG_W +: TAG_W].
- req_data  input  NUM_REQ*DATA_W  flattened results; unit i at [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  combinational one-hot grant; handshake when req_valid[i] & req_ready[i].
- cdb_valid  output  1  registered broadcast valid.
- cdb_tag  output  TAG_W  registered broadcast tag.
- cdb_data  output  DATA_W  registered broadcast data.
- cdb_src  output  3  registered index of the unit that produced the current broadcast.
- perf_sel  input  3  counter select; used only with CDB_GRANT_COUNT_EN.
- perf_count  output  16  selected grant counter; reads 0 without CDB_GRANT_COUNT_EN.

Behaviour:
- Reset values:
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - rr_ptr=0; all grant counters=0.
  - req_ready is combinational and therefore 0 whenever req_valid=0.
- Arbitration (combinational):
  - Search starts at rr_ptr and proceeds upward modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1.
  - At most one ready bit is set in any cycle.
  - When flush=1, req_ready is all zeros.
- Pointer update: on a handshake with unit g, rr_ptr <= (g+1) mod NUM_REQ. With no handshake, rr_ptr holds. flush does not move rr_ptr.
- Broadcast latency: a handshake in cycle t produces cdb_valid=1 in cycle t+1, carrying req_tag/req_data of g sampled at the edge, with cdb_src=g.
- cdb_valid is high for exactly one cycle per handshake. With no handshake in cycle t, cdb_valid=0 in cycle t+1 and tag/data/src hold their previous values.
- Back-to-back: one broadcast per cycle is sustainable. Continuous requests from all units yield grants 0,1,2,3,0,... with no idle cycles.
- Requester protocol:
  - A unit must hold req_valid, req_tag and req_data stable until it sees req_ready.
  - It may drop req_valid only after the handshake cycle.
  - Deasserting req_valid before the handshake is a protocol violation; the arbiter simply stops considering that unit.
- Starvation bound: a continuously requesting unit is granted within NUM_REQ cycles.
- Flush:
  - flush=1 in cycle t: no handshake in t, and cdb_valid=0 in t+1.
  - A broadcast already on the CDB in cycle t (from a grant in t-1) still completes.
  - Flushed requesters keep their req_valid until their own units are flushed.
- Reset mid-operation: asynchronous reset immediately forces cdb_valid=0 and rr_ptr=0. Any in-flight broadcast is lost.
- Widths:
  - rr_ptr is 3 bits and wraps at NUM_REQ, not at 8.
  - cdb_src is zero-extended to 3 bits.

Optional Feature:
- Macro CDB_GRANT_COUNT_EN.
- Defined:
  - One 16-bit saturating grant counter per unit; it increments on each handshake of that unit and is not cleared by flush.
  - perf_count = counter[perf_sel]; a perf_sel >= NUM_REQ reads 0.
  - Counters reset to 0 on reset and saturate at 16'hFFFF.
- Undefined: no counters are synthesized, perf_count is tied to 0, and perf_sel is ignored.

Test Plan:
- Reset, then req_valid=4'b0000 -> cdb_valid=0 and req_ready=0 on every cycle.
- Single request: req_valid=4'b0100, tag=6'd17, data=32'hDEADBEEF -> req_ready=4'b0100 in the same cycle; next cycle cdb_valid=1, cdb_tag=17, cdb_data=DEADBEEF, cdb_src=2; cycle after, cdb_valid=0.
- All four units requesting for 8 cycles -> grant order 0,1,2,3,0,1,2,3; cdb_valid=1 for 8 consecutive cycles, starting one cycle after the first grant.
- Granting unit 1, then units 0 and 1 both requesting -> unit 0 granted first, since rr_ptr=2 wraps past 3 to 0.
- flush=1 in the cycle units 0 and 3 request with rr_ptr=3 -> req_ready=0 and next-cycle cdb_valid=0; after flush drops, unit 3 is granted first.
- CDB_GRANT_COUNT_EN defined: 5 handshakes by unit 1 with perf_sel=1 -> perf_count=5; assert reset mid-stream -> cdb_valid=0 and perf_count=0 immediately.
